// File: rtl/addsub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM state
// encoding, operation select constants and a counter-width helper.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Width of the chunk counter: enough to index every chunk, never below 1 bit.
    function automatic int cnt_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// K-bit combinational ripple-carry adder slice. Besides the sum and the
// carry out it exposes the carry into its top bit, so the last slice of a
// word can report signed overflow.
module addsub_chunk #(
    parameter int K = 4
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         cin,
    output logic [K-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [K:0] c;

    // Ripple the carry through the slice one bit at a time.
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < K; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[K];
        cmsb = c[K-1];
    end

endmodule

// File: rtl/addsub_chunked.sv
// Multi-cycle adder/subtractor: one K-bit chunk per clock, N/K cycles per
// operation, valid/ready handshake on both sides, one operation in flight.
// Subtraction is x + ~y + 1, so c_out = 1 means "no borrow".
// Optional build macro ADDSUB_CHUNKED_SAT_EN: saturate s on signed overflow
// (flags still describe the unsaturated result; zero follows saturated s).
module addsub_chunked
    import addsub_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         add_n,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         overflow,
    output logic         zero
);

    localparam int NK = N / K;
    localparam int CW = cnt_width(NK);
    localparam logic [CW-1:0] LAST = CW'(NK - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  s_q, s_d;
    logic          carry_q, carry_d;
    logic          c_out_q, c_out_d;
    logic          ovf_q, ovf_d;
    logic          zero_q, zero_d;

    logic [31:0]   base;
    logic [K-1:0]  ch_a, ch_b, ch_sum;
    logic          ch_cout, ch_cmsb;
    logic [N-1:0]  res_full;
    logic [N-1:0]  s_final;
    logic          ovf_now;

    addsub_chunk #(.K(K)) u_chunk (
        .a    (ch_a),
        .b    (ch_b),
        .cin  (carry_q),
        .sum  (ch_sum),
        .cout (ch_cout),
        .cmsb (ch_cmsb)
    );

    // Select the active chunk and merge its sum into the partial result.
    always_comb begin
        base     = 32'(cnt_q) * 32'(K);
        ch_a     = a_q[base +: K];
        ch_b     = b_q[base +: K];
        res_full = s_q;
        res_full[base +: K] = ch_sum;
    end

    // Final result as written on the last chunk, saturated when enabled.
    always_comb begin
        ovf_now = ch_cmsb ^ ch_cout;
        s_final = res_full;
`ifdef ADDSUB_CHUNKED_SAT_EN
        if (ovf_now) begin
            s_final = a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
`endif
    end

    // Next-state and datapath update for the IDLE/CALC/DONE sequence.
    // NOTE: every _d gets its hold value first, so no path leaves a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = x;
                    b_d     = (add_n == OP_ADD) ? y : ~y;
                    carry_d = (add_n == OP_SUB);
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                s_d     = res_full;
                carry_d = ch_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    s_d     = s_final;
                    c_out_d = ch_cout;
                    ovf_d   = ovf_now;
                    zero_d  = (s_final == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_chunked.sv
// Scoreboard bench for addsub_chunked at N=8, K=4 (two cycles per op).
// Directed vectors push hand-computed results; a monitor pops and compares
// on every out_valid & out_ready.
module tb_addsub_chunked;

    localparam int N = 8;
    localparam int K = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] x, y;
    logic         add_n;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] s;
    logic         c_out;
    logic         overflow;
    logic         zero;

    typedef struct packed {
        logic [N-1:0] s;
        logic         c;
        logic         o;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    addsub_chunked #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .add_n     (add_n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one pop per completed handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got s=0x%0h with nothing expected", s);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_s", 32'(s), 32'(e.s));
                check("res_c_out", 32'(c_out), 32'(e.c));
                check("res_overflow", 32'(overflow), 32'(e.o));
                check("res_zero", 32'(zero), 32'(e.z));
            end
        end
    end

    task automatic push_exp(input logic [N-1:0] s_wrap, input logic [N-1:0] s_sat,
                            input logic c, input logic o);
        exp_t e;
`ifdef ADDSUB_CHUNKED_SAT_EN
        e.s = s_sat;
`else
        e.s = s_wrap;
`endif
        e.c = c;
        e.o = o;
        e.z = (e.s == '0);
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Present one operation and return 1 time unit after its accepting edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic op,
                        input logic [N-1:0] s_wrap, input logic [N-1:0] s_sat,
                        input logic c, input logic o, input bit expect_res);
        wait_ready();
        x        = a;
        y        = b;
        add_n    = op;
        in_valid = 1'b1;
        if (expect_res) push_exp(s_wrap, s_sat, c, o);
        @(posedge clk); #1;
        in_valid = 1'b0;
        x        = 8'($urandom);
        y        = 8'($urandom);
        add_n    = ~op;
    endtask

    // Count edges from acceptance to out_valid.
    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 32'(n), 32'd2);
    endtask

    task automatic run_op(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic op, input logic [N-1:0] s_wrap, input logic [N-1:0] s_sat,
                          input logic c, input logic o);
        send(a, b, op, s_wrap, s_sat, c, o, 1'b1);
        wait_valid(name);
        @(posedge clk); #1;
    endtask

    logic [N-1:0] bx[4] = '{8'h01, 8'h10, 8'h55, 8'h0F};
    logic [N-1:0] by[4] = '{8'h01, 8'h20, 8'hAA, 8'h0F};
    logic         bo[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [N-1:0] bs[4] = '{8'h02, 8'hF0, 8'hFF, 8'h00};
    logic         bc[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int           acc_t[4];

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        add_n     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_flags", {29'd0, c_out, overflow, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed add/subtract vectors, including overflow in both directions.
        run_op("lat_add_3_8",    8'h03, 8'h08, 1'b0, 8'h0B, 8'h0B, 1'b0, 1'b0);
        run_op("lat_sub_2_6",    8'h02, 8'h06, 1'b1, 8'hFC, 8'hFC, 1'b0, 1'b0);
        run_op("lat_sub_8_8",    8'h08, 8'h08, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0);
        run_op("lat_add_7f_01",  8'h7F, 8'h01, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1);
        run_op("lat_sub_80_01",  8'h80, 8'h01, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1);
        run_op("lat_add_ff_01",  8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        run_op("lat_add_80_80",  8'h80, 8'h80, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1);

        // Consumer stalls for 5 cycles in DONE while new requests are offered.
        out_ready = 1'b0;
        send(8'h25, 8'h13, 1'b0, 8'h38, 8'h38, 1'b0, 1'b0, 1'b1);
        wait_valid("lat_hold");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            x        = 8'($urandom);
            y        = 8'($urandom);
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_s", 32'(s), 32'h38);
            check("hold_flags", {29'd0, c_out, overflow, zero}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;

        // Reset during the first CALC cycle throws the operation away.
        send(8'h11, 8'h22, 1'b0, 8'h33, 8'h33, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_s", 32'(s), 32'd0);
        check("midrst_flags", {29'd0, c_out, overflow, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("lat_after_rst", 8'h04, 8'h05, 1'b0, 8'h09, 8'h09, 1'b0, 1'b0);

        // Back-to-back: in_valid never drops, one result every N/K+2 cycles.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x     = bx[i];
            y     = by[i];
            add_n = bo[i];
            wait_ready();
            push_exp(bs[i], bs[i], bc[i], 1'b0);
            @(posedge clk); #1;
            acc_t[i] = cyc;
            if (i > 0) check("b2b_period", 32'(acc_t[i] - acc_t[i-1]), 32'd4);
        end
        x = 8'hA5;
        y = 8'h5A;
        wait_ready();
        in_valid = 1'b0;

        begin
            int t = 0;
            while (sb.size() != 0 && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("final_out_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
